// File: rtl/dmem_pkg.sv
// Shared encodings for the sized data-memory controller: access sizes, FSM states,
// read-latency limits and the byte-lane enable helper.
package dmem_pkg;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // The offset passed in is already naturally aligned, so a half only ever shifts by 0 or 2.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    lane_mask = 4'b0001 << off;
            SZ_H:    lane_mask = 4'b0011 << off;
            SZ_W:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_bank.sv
// One byte lane of the data memory: synchronous write, combinational read at the same index.
module dmem_byte_bank #(
    parameter int DEPTH = 65536,
    parameter int IW    = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_sized_ctrl.sv
// Byte-banked data memory with sized loads/stores and a valid/ready handshake.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses instead of aligning them down.
import dmem_pkg::*;

module dmem_sized_ctrl #(
    parameter int DEPTH_WORDS = 65536,
    parameter int RD_LAT      = 1,
    parameter int AW          = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_wen,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    localparam int IW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [2:0] CNT_INIT = 3'(LAT - 1);

    state_t        state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [1:0]    off_q, off_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          wen_q, wen_d;
    logic          err_q, err_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic [1:0]    addr_lo;
    logic          align_err;
    logic          req_err;
    logic [IW-1:0] req_idx;
    logic [3:0]    lane_we;
    logic [31:0]   wdata_rep;
    logic [7:0]    bank_rdata [4];
    logic [IW-1:0] bank_idx;

    logic [1:0]    cur_off, cur_size;
    logic          cur_uns, cur_wen, cur_err;
    logic [31:0]   rd_word, rd_shift, load_data;
    logic          enter_resp;

    assign accept  = (state_q == ST_IDLE) && req_valid;
    assign req_idx = req_addr[IW+1:2];

    // Natural alignment: either fault the access or silently clear the low address bits.
    always_comb begin
        addr_lo   = req_addr[1:0];
        align_err = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        if (req_size == SZ_H) begin
            align_err = req_addr[0];
        end else if (req_size == SZ_W) begin
            align_err = |req_addr[1:0];
        end
`else
        if (req_size == SZ_H) begin
            addr_lo[0] = 1'b0;
        end else if (req_size == SZ_W) begin
            addr_lo = 2'b00;
        end
`endif
    end

    assign req_err = (req_size == SZ_RSV) || align_err ||
                     ({2'b00, req_addr[AW-1:2]} >= AW'(DEPTH_WORDS));

    always_comb begin
        case (req_size)
            SZ_B:    wdata_rep = {4{req_wdata[7:0]}};
            SZ_H:    wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
        lane_we = (accept && req_wen && !req_err) ? lane_mask(req_size, addr_lo) : 4'b0000;
    end

    // In IDLE the live request drives the banks so a latency-1 read lands at the accept edge.
    assign bank_idx = (state_q == ST_IDLE) ? req_idx : idx_q;

    for (genvar g = 0; g < 4; g++) begin : g_bank
        dmem_byte_bank #(.DEPTH(DEPTH_WORDS), .IW(IW)) u_bank (
            .clk   (clk),
            .we    (lane_we[g]),
            .idx   (bank_idx),
            .wdata (wdata_rep[8*g +: 8]),
            .rdata (bank_rdata[g])
        );
    end

    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_off  = addr_lo;
            cur_size = req_size;
            cur_uns  = req_unsigned;
            cur_wen  = req_wen;
            cur_err  = req_err;
        end else begin
            cur_off  = off_q;
            cur_size = size_q;
            cur_uns  = uns_q;
            cur_wen  = wen_q;
            cur_err  = err_q;
        end
        rd_word  = {bank_rdata[3], bank_rdata[2], bank_rdata[1], bank_rdata[0]};
        rd_shift = rd_word >> {cur_off, 3'b000};
        case (cur_size)
            SZ_B:    load_data = cur_uns ? {24'h0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
            SZ_H:    load_data = cur_uns ? {16'h0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wen_d       = wen_q;
        err_d       = err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    idx_d  = req_idx;
                    off_d  = addr_lo;
                    size_d = req_size;
                    uns_d  = req_unsigned;
                    wen_d  = req_wen;
                    err_d  = req_err;
                    cnt_d  = CNT_INIT;
                    if (LAT == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_resp) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_err;
            rsp_rdata_d = (cur_wen || cur_err) ? 32'h0 : load_data;
        end
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            idx_q       <= '0;
            off_q       <= 2'd0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            wen_q       <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            wen_q       <= wen_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized_ctrl.sv
// Directed bench for dmem_sized_ctrl: two instances (read latency 1 and 3) sharing
// request fields; expectations follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_sized_ctrl;

    localparam int DW = 256;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_wen, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_valid1, req_ready1, rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;
    logic        req_valid3, req_ready3, rsp_valid3, rsp_ready3, rsp_err3;
    logic [31:0] rsp_rdata3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_sized_ctrl #(.DEPTH_WORDS(DW), .RD_LAT(1), .AW(32)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
    );

    dmem_sized_ctrl #(.DEPTH_WORDS(DW), .RD_LAT(3), .AW(32)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_wen(req_wen),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full transaction; returns response fields and cycles from accept to rsp_valid.
    task automatic applyStimulus(input bit which, input logic wen, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        int n;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        if (which) req_valid3 = 1'b1; else req_valid1 = 1'b1;
        n = 0;
        while (!(which ? req_ready3 : req_ready1) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid1   = 1'b0;
        req_valid3   = 1'b0;
        req_addr     = 32'hFFFF_FFFF;
        req_size     = 2'd3;
        req_wdata    = 32'hFFFF_FFFF;
        req_wen      = ~wen;
        req_unsigned = ~uns;
        lat = 1;
        while (!(which ? rsp_valid3 : rsp_valid1) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!(which ? rsp_valid3 : rsp_valid1)) begin
            checkOutput("rsp_timeout", 32'd0, 32'd1);
        end
        rdata = which ? rsp_rdata3 : rsp_rdata1;
        err   = which ? rsp_err3 : rsp_err1;
        if (which) rsp_ready3 = 1'b1; else rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        rsp_ready3 = 1'b0;
    endtask

    task automatic access(input string tag, input bit which, input logic wen, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        int          lat;
        applyStimulus(which, wen, size, uns, addr, wdata, rd, er, lat);
        checkOutput({tag, "_rdata"}, rd, exp_rdata);
        checkOutput({tag, "_err"}, 32'(er), 32'(exp_err));
        checkOutput({tag, "_lat"}, 32'(lat), which ? 32'd3 : 32'd1);
    endtask

    initial begin : main
        logic [31:0] w10;
        logic        seen;
        rst = 1'b1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
        req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_req_ready", 32'(req_ready1), 32'd1);
        checkOutput("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata1, 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err1), 32'd0);

        access("sw10", 0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lw10", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        access("sw10_l3", 1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
        access("lw10_l3", 1, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);

        access("sw10_zero", 0, 1, 2'd2, 0, 32'h10, 32'h0, 32'h0, 0);
        access("sb13", 0, 1, 2'd0, 0, 32'h13, 32'hFFFF_FF80, 32'h0, 0);
        access("lw10_b", 0, 0, 2'd2, 0, 32'h10, 32'h0, 32'h8000_0000, 0);
        access("lb13", 0, 0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFF_FF80, 0);
        access("lbu13", 0, 0, 2'd0, 1, 32'h13, 32'h0, 32'h0000_0080, 0);

        access("sw20", 0, 1, 2'd2, 0, 32'h20, 32'hA5A5_A5A5, 32'h0, 0);
        access("sh20", 0, 1, 2'd1, 0, 32'h20, 32'hFFFF_8001, 32'h0, 0);
        access("sh22", 0, 1, 2'd1, 0, 32'h22, 32'h0000_1234, 32'h0, 0);
        access("lh22", 0, 0, 2'd1, 0, 32'h22, 32'h0, 32'h0000_1234, 0);
        access("lh20", 0, 0, 2'd1, 0, 32'h20, 32'h0, 32'hFFFF_8001, 0);
        access("lhu20", 0, 0, 2'd1, 1, 32'h20, 32'h0, 32'h0000_8001, 0);
        access("lw20", 0, 0, 2'd2, 0, 32'h20, 32'h0, 32'h1234_8001, 0);

        access("lw11", 0, 0, 2'd2, 0, 32'h11, 32'h0, ALIGN_CHK ? 32'h0 : 32'h8000_0000, ALIGN_CHK);
        access("sw12", 0, 1, 2'd2, 0, 32'h12, 32'h1122_3344, 32'h0, ALIGN_CHK);
        w10 = ALIGN_CHK ? 32'h8000_0000 : 32'h1122_3344;
        access("lw10_mis", 0, 0, 2'd2, 0, 32'h10, 32'h0, w10, 0);

        // Response held for five cycles with a competing request pending.
        req_wen = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid1 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", 32'(rsp_valid1), 32'd1);
            checkOutput("hold_rdata", rsp_rdata1, w10);
            checkOutput("hold_err", 32'(rsp_err1), 32'd0);
            checkOutput("hold_ready", 32'(req_ready1), 32'd0);
            @(posedge clk); #1;
        end
        rsp_ready1 = 1'b1;
        @(posedge clk); #1;
        rsp_ready1 = 1'b0;
        checkOutput("hs_ready_back", 32'(req_ready1), 32'd1);
        checkOutput("hs_no_accept", 32'(rsp_valid1), 32'd0);
        req_valid1 = 1'b0;

        access("lrsv", 0, 0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
        access("srsv", 0, 1, 2'd3, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 1);
        access("lw10_rsv", 0, 0, 2'd2, 0, 32'h10, 32'h0, w10, 0);
        access("sw00", 0, 1, 2'd2, 0, 32'h0, 32'h0102_0304, 32'h0, 0);
        access("sw_oor", 0, 1, 2'd2, 0, 32'h400, 32'hCAFE_F00D, 32'h0, 1);
        access("lw00", 0, 0, 2'd2, 0, 32'h0, 32'h0, 32'h0102_0304, 0);
        access("lw_oor", 0, 0, 2'd2, 0, 32'h400, 32'h0, 32'h0, 1);

        // Reset while the latency-3 instance waits on an accepted store.
        req_wen = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h600D_F00D;
        req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (rsp_valid3) seen = 1'b1;
            @(posedge clk); #1;
        end
        checkOutput("rst_wait_no_rsp", 32'(seen), 32'd0);
        checkOutput("rst_wait_ready", 32'(req_ready3), 32'd1);
        access("lw40_l3", 1, 0, 2'd2, 0, 32'h40, 32'h0, 32'h600D_F00D, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
